// File: rtl/read_sched_pkg.sv
// Package read_sched_pkg
// Shared types and constants for the read job scheduler.
// - t_sched_state : scheduler FSM states
// - t_job_desc    : queued job descriptor {cache-line address, length in lines}
// - chunk_of()    : lines to launch in the next engine run
package read_sched_pkg;

    localparam int ADDR_W        = 42;  // cache-line address width
    localparam int LEN_W         = 32;  // job length width, in lines
    localparam int DEF_QDEPTH    = 4;   // job FIFO depth (power of 2)
    localparam int DEF_MAX_CHUNK = 64;  // max lines per engine run

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        ARM,
        WAIT_DONE
    } t_sched_state;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } t_job_desc;

    // Size of the next chunk: whatever is left, capped at the per-run limit.
    function automatic logic [LEN_W-1:0] chunk_of(input logic [LEN_W-1:0] remaining,
                                                  input logic [LEN_W-1:0] max_chunk);
        return (remaining > max_chunk) ? max_chunk : remaining;
    endfunction

endpackage

// File: rtl/read_job_scheduler_if.sv
// Interface read_job_scheduler_if
// Bundles the job-submission handshake, the read-engine control/status
// signals and the scheduler status outputs.
// - slave  : scheduler view (accepts jobs, drives the engine)
// - master : host/engine side view (offers jobs, reports engine done)
interface read_job_scheduler_if;

    // Job submission
    logic                               job_valid;
    logic                               job_ready;
    logic [read_sched_pkg::ADDR_W-1:0]  job_addr;
    logic [read_sched_pkg::LEN_W-1:0]   job_len;
    logic                               abort;

    // Read engine
    logic                               rd_run;
    logic [read_sched_pkg::ADDR_W-1:0]  rd_first_clAddr;
    logic [63:0]                        rd_data_length;
    logic                               rd_done;

    // Status
    logic                               job_done;
    logic                               job_aborted;
    logic                               busy;
    logic [31:0]                        lines_done;

    modport slave (
        input  job_valid, job_addr, job_len, abort, rd_done,
        output job_ready, rd_run, rd_first_clAddr, rd_data_length,
               job_done, job_aborted, busy, lines_done
    );

    modport master (
        output job_valid, job_addr, job_len, abort, rd_done,
        input  job_ready, rd_run, rd_first_clAddr, rd_data_length,
               job_done, job_aborted, busy, lines_done
    );

endinterface

// File: rtl/job_desc_fifo.sv
// Module job_desc_fifo
// Synchronous FIFO of job descriptors, no bypass.
// Ports: clk, reset (async active-low), push/push_data, pop/head,
//        flush (drops everything queued before this cycle), full, empty.
module job_desc_fifo
    import read_sched_pkg::*;
#(
    parameter int DEPTH = DEF_QDEPTH
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  t_job_desc push_data,
    input  logic      pop,
    input  logic      flush,
    output t_job_desc head,
    output logic      full,
    output logic      empty
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    t_job_desc        mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    // NOTE: the storage array is not reset; the pointers alone decide which
    // entries are valid, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            // Flush moves the read pointer to the pre-push write pointer, so a
            // descriptor written in the flush cycle itself stays queued.
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    assign head  = mem[rd_ptr[PTR_W-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/read_job_scheduler.sv
// Module read_job_scheduler
// Queues (address, length) read jobs and feeds them to the read engine in
// chunks of at most MAX_CHUNK lines, one engine run at a time.
// Ports:
//   clk, reset (async active-low, shared with the read engine)
//   bus.slave: job_valid/job_ready/job_addr/job_len/abort from the host side;
//              rd_run/rd_first_clAddr/rd_data_length out to the engine and
//              rd_done back; job_done/job_aborted pulses, busy, lines_done.
module read_job_scheduler
    import read_sched_pkg::*;
#(
    parameter int QDEPTH    = DEF_QDEPTH,
    parameter int MAX_CHUNK = DEF_MAX_CHUNK
) (
    input logic                 clk,
    input logic                 reset,
    read_job_scheduler_if.slave bus
);

    localparam logic [LEN_W-1:0] MAX_CHUNK_L = LEN_W'(MAX_CHUNK);

    t_sched_state      state, state_nxt;
    logic              ready_en;      // holds job_ready low until the first clock after reset
    logic              abort_pend;
    logic [ADDR_W-1:0] run_addr;      // start address of the current chunk
    logic [LEN_W-1:0]  remaining;     // lines left in the job, current chunk included
    logic [LEN_W-1:0]  chunk;         // lines in the current chunk
    logic              job_done_q;
    logic              job_aborted_q;
    logic [31:0]       lines_done_q;

    // FSM decisions
    logic              fifo_push, fifo_pop, fifo_flush;
    logic              fifo_full, fifo_empty;
    t_job_desc         fifo_head;
    logic              load_run;
    logic [ADDR_W-1:0] next_addr;
    logic [LEN_W-1:0]  next_rem;
    logic              done_set, aborted_set, retire;
    logic [LEN_W-1:0]  rem_after;
    logic [ADDR_W-1:0] addr_after;

    assign fifo_push = bus.job_valid && bus.job_ready;

    job_desc_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ('{addr: bus.job_addr, len: bus.job_len}),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rem_after  = remaining - chunk;
    assign addr_after = run_addr + ADDR_W'(chunk);   // wraps modulo 2^ADDR_W

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        load_run    = 1'b0;
        next_addr   = run_addr;
        next_rem    = remaining;
        done_set    = 1'b0;
        aborted_set = 1'b0;
        retire      = 1'b0;

        unique case (state)
            IDLE: begin
                if (abort_pend) begin
                    fifo_flush  = 1'b1;
                    aborted_set = 1'b1;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (fifo_head.len == '0) begin
                        done_set = 1'b1;
                    end else begin
                        load_run  = 1'b1;
                        next_addr = fifo_head.addr;
                        next_rem  = fifo_head.len;
                        state_nxt = LAUNCH;
                    end
                end
            end
            LAUNCH: state_nxt = ARM;
            // The engine still reports idle during the run cycle, so rd_done
            // is only trusted from WAIT_DONE onward.
            ARM: state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.rd_done) begin
                    retire = 1'b1;
                    if (rem_after == '0) begin
                        done_set  = 1'b1;
                        state_nxt = IDLE;
                    end else if (abort_pend) begin
                        state_nxt = IDLE;
                    end else begin
                        load_run  = 1'b1;
                        next_addr = addr_after;
                        next_rem  = rem_after;
                        state_nxt = LAUNCH;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ready_en      <= 1'b0;
            abort_pend    <= 1'b0;
            run_addr      <= '0;
            remaining     <= '0;
            chunk         <= '0;
            job_done_q    <= 1'b0;
            job_aborted_q <= 1'b0;
            lines_done_q  <= '0;
        end else begin
            state         <= state_nxt;
            ready_en      <= 1'b1;
            // An abort arriving in the flush cycle survives for the next flush.
            abort_pend    <= bus.abort || (abort_pend && !fifo_flush);
            job_done_q    <= done_set;
            job_aborted_q <= aborted_set;
            // Chunk parameters change only when a run is about to launch, which
            // keeps them stable from LAUNCH until WAIT_DONE is left.
            if (load_run) begin
                run_addr  <= next_addr;
                remaining <= next_rem;
                chunk     <= chunk_of(next_rem, MAX_CHUNK_L);
            end
            if (retire) begin
                lines_done_q <= lines_done_q + 32'(chunk);
            end
        end
    end

    assign bus.job_ready       = ready_en && !fifo_full;
    assign bus.rd_run          = (state == LAUNCH);
    assign bus.rd_first_clAddr = run_addr;
    assign bus.rd_data_length  = 64'(chunk);
    assign bus.job_done        = job_done_q;
    assign bus.job_aborted     = job_aborted_q;
    assign bus.busy            = (state != IDLE) || !fifo_empty;
    assign bus.lines_done      = lines_done_q;

endmodule
